band8_distributor: RTL and testbench

- 1-to-8 distributor: the inverse of the 8-to-1 band selector. Routes one 4-bit input stream to one of eight output channels.
- Each channel has a one-deep registered slot and a valid/ready handshake.
- Target channel is chosen by an explicit ctrl select or by an internal round-robin pointer.
- Sits upstream of per-band consumers; pairs with band8_selector for loopback tests.

---
 rtl/band8_pkg.sv | 8 +
 rtl/band8_slot.sv | 36 +++
 rtl/band8_distributor.sv | 54 +++++
 tb/tb_band8_distributor.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/band8_pkg.sv
// band8_pkg: shared constants and types for the band8 distributor
package band8_pkg;
    localparam int WIDTH = 4;
    localparam int NCH   = 8;
    localparam int SEL_W = 3;
    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [WIDTH-1:0] sample_t;
endpackage

// File: rtl/band8_slot.sv
// band8_slot: one-deep output slot; BAND8_DIST_HOLD_EN keeps the last data visible after drain
module band8_slot
    import band8_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] in_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);
    logic    valid_q, valid_d;
    sample_t data_q, data_d;
    // a load wins over a drain so a slot can be emptied and refilled on one edge
    always_comb begin
        valid_d = load ? 1'b1 : (drain ? 1'b0 : valid_q);
        data_d  = load ? in_data : data_q;
    end
    // slot state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
    assign valid = valid_q;
`ifdef BAND8_DIST_HOLD_EN
    assign data = data_q;
`else
    assign data = valid_q ? data_q : '0;
`endif
endmodule

// File: rtl/band8_distributor.sv
// band8_distributor: routes one input stream to one of eight handshaked slots (build option BAND8_DIST_HOLD_EN)
module band8_distributor
    import band8_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     ctrl,
    input  logic                 rr_mode,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic                 busy,
    output logic [7:0]           acc_cnt
);
    sel_t           sel, rr_ptr_q, rr_ptr_d;
    logic [7:0]     acc_cnt_q, acc_cnt_d;
    logic           accept;
    logic [NCH-1:0] load;
    // target selection and handshake; a draining target counts as free this cycle
    always_comb begin
        sel       = rr_mode ? rr_ptr_q : ctrl;
        in_ready  = !out_valid[sel] || out_ready[sel];
        accept    = in_valid && in_ready;
        load      = accept ? (NCH'(1) << sel) : '0;
        rr_ptr_d  = (accept && rr_mode) ? rr_ptr_q + 1'b1 : rr_ptr_q;
        acc_cnt_d = acc_cnt_q + 8'(accept);
        busy      = |out_valid;
    end
    // pointer and transfer counter; both wrap naturally at their widths
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            acc_cnt_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            acc_cnt_q <= acc_cnt_d;
        end
    end
    assign acc_cnt = acc_cnt_q;
    for (genvar i = 0; i < NCH; i++) begin : g_slot
        band8_slot u_slot (
            .clk     (clk),
            .rst     (rst),
            .load    (load[i]),
            .drain   (out_valid[i] && out_ready[i]),
            .in_data (in_data),
            .valid   (out_valid[i]),
            .data    (out_data[i*WIDTH +: WIDTH])
        );
    end
endmodule

// File: tb/tb_band8_distributor.sv
// tb_band8_distributor: directed checks of routing, backpressure, round-robin, async reset and hold option
module tb_band8_distributor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  ctrl = '0;
    logic        rr_mode = 1'b0;
    logic [31:0] out_data;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready = '0;
    logic        busy;
    logic [7:0]  acc_cnt;
    int total = 0;
    int bad = 0;

    band8_distributor dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .ctrl(ctrl), .rr_mode(rr_mode), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .acc_cnt(acc_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = '0;
        rr_mode = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL reset_valid got=%h exp=%h", out_valid, 8'h00); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=%h", out_data, 32'h0); end
        total++; if (acc_cnt !== 8'h00) begin bad++; $display("FAIL reset_acc got=%h exp=%h", acc_cnt, 8'h00); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_explicit();
        rr_mode = 1'b0; ctrl = 3'd5; in_data = 4'hA; in_valid = 1'b1; out_ready = '0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL expl_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 8'b0010_0000) begin bad++; $display("FAIL expl_valid got=%b exp=%b", out_valid, 8'b0010_0000); end
        total++; if (out_data[23:20] !== 4'hA) begin bad++; $display("FAIL expl_data got=%h exp=a", out_data[23:20]); end
        total++; if (acc_cnt !== 8'd1) begin bad++; $display("FAIL expl_acc got=%0d exp=1", acc_cnt); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL expl_busy got=%b exp=1", busy); end
    endtask

    task automatic test_backpressure();
        ctrl = 3'd5; in_data = 4'h3; in_valid = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_low got=%b exp=0", in_ready); end
        step();
        total++; if (out_data[23:20] !== 4'hA) begin bad++; $display("FAIL bp_hold got=%h exp=a", out_data[23:20]); end
        total++; if (acc_cnt !== 8'd1) begin bad++; $display("FAIL bp_acc_stall got=%0d exp=1", acc_cnt); end
        out_ready[5] = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_high got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0; out_ready = '0;
        total++; if (out_valid !== 8'b0010_0000) begin bad++; $display("FAIL bp_refill_valid got=%b exp=%b", out_valid, 8'b0010_0000); end
        total++; if (out_data[23:20] !== 4'h3) begin bad++; $display("FAIL bp_refill_data got=%h exp=3", out_data[23:20]); end
        total++; if (acc_cnt !== 8'd2) begin bad++; $display("FAIL bp_acc got=%0d exp=2", acc_cnt); end
        out_ready = 8'hFF;
        step();
        out_ready = '0;
        total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_busy got=%b exp=0", busy); end
    endtask

    task automatic test_rr_wrap();
        do_reset();
        rr_mode = 1'b1; out_ready = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            in_data = 4'(k); in_valid = 1'b1;
            step();
            total++; if (out_valid !== (8'h01 << (k % 8))) begin bad++; $display("FAIL rr_valid k=%0d got=%b exp=%b", k, out_valid, 8'h01 << (k % 8)); end
            total++; if (out_data[(k % 8)*4 +: 4] !== 4'(k)) begin bad++; $display("FAIL rr_data k=%0d got=%h exp=%h", k, out_data[(k % 8)*4 +: 4], 4'(k)); end
        end
        in_valid = 1'b0;
        step();
        total++; if (acc_cnt !== 8'd10) begin bad++; $display("FAIL rr_acc got=%0d exp=10", acc_cnt); end
        total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL rr_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_mode_switch();
        do_reset();
        rr_mode = 1'b1; out_ready = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            in_data = 4'(k + 1); in_valid = 1'b1;
            step();
        end
        rr_mode = 1'b0; ctrl = 3'd6;
        for (int k = 0; k < 2; k++) begin
            in_data = 4'(k + 4); in_valid = 1'b1;
            step();
            total++; if (out_valid !== 8'h40) begin bad++; $display("FAIL ms_ctrl_valid k=%0d got=%b exp=%b", k, out_valid, 8'h40); end
            total++; if (out_data[27:24] !== 4'(k + 4)) begin bad++; $display("FAIL ms_ctrl_data k=%0d got=%h exp=%h", k, out_data[27:24], 4'(k + 4)); end
        end
        rr_mode = 1'b1; in_data = 4'h9;
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 8'h08) begin bad++; $display("FAIL ms_rr_valid got=%b exp=%b", out_valid, 8'h08); end
        total++; if (out_data[15:12] !== 4'h9) begin bad++; $display("FAIL ms_rr_data got=%h exp=9", out_data[15:12]); end
        total++; if (acc_cnt !== 8'd6) begin bad++; $display("FAIL ms_acc got=%0d exp=6", acc_cnt); end
    endtask

    task automatic test_async_reset();
        do_reset();
        rr_mode = 1'b1; out_ready = '0;
        for (int k = 0; k < 4; k++) begin
            in_data = 4'(k + 8); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        total++; if (out_valid !== 8'h0F) begin bad++; $display("FAIL ar_fill got=%b exp=%b", out_valid, 8'h0F); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL ar_valid got=%b exp=0", out_valid); end
        total++; if (acc_cnt !== 8'd0) begin bad++; $display("FAIL ar_acc got=%0d exp=0", acc_cnt); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL ar_data got=%h exp=0", out_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ar_busy got=%b exp=0", busy); end
        step();
        rst = 1'b0;
        in_data = 4'hC; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 8'h01) begin bad++; $display("FAIL ar_rr_ptr got=%b exp=%b", out_valid, 8'h01); end
        total++; if (out_data[3:0] !== 4'hC) begin bad++; $display("FAIL ar_rr_data got=%h exp=c", out_data[3:0]); end
    endtask

    task automatic test_hold();
        logic [3:0] exp_after;
`ifdef BAND8_DIST_HOLD_EN
        exp_after = 4'h7;
`else
        exp_after = 4'h0;
`endif
        do_reset();
        rr_mode = 1'b0; ctrl = 3'd2; in_data = 4'h7; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        total++; if (out_data[11:8] !== 4'h7) begin bad++; $display("FAIL hold_load got=%h exp=7", out_data[11:8]); end
        out_ready = 8'hFF;
        step();
        out_ready = '0;
        total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL hold_drain got=%b exp=0", out_valid); end
        total++; if (out_data[11:8] !== exp_after) begin bad++; $display("FAIL hold_data got=%h exp=%h", out_data[11:8], exp_after); end
    endtask

    initial begin
        test_reset();
        test_explicit();
        test_backpressure();
        test_rr_wrap();
        test_mode_switch();
        test_async_reset();
        test_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
